// File: rtl/twofish_ctr_sequencer.sv
// Sequences one Twofish-CTR stream through an external core, one block at a time: LOAD -> RUN -> OUT.
// Optional RUN watchdog with sticky error output is enabled by defining TWOFISH_SEQ_TIMEOUT_EN.
module twofish_ctr_sequencer #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic [63:0]      first_block_i,
  input  logic [CNT_W-1:0] num_blocks_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             core_rst,
  output logic [127:0]     core_key,
  output logic [127:0]     core_iv,
  output logic [63:0]      core_block_number,
  output logic [127:0]     core_text_input,
  input  logic [127:0]     core_text_output,
  input  logic             core_end
`ifdef TWOFISH_SEQ_TIMEOUT_EN
  ,
  output logic             error
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       iv_q, iv_d;
  logic [63:0]        blk_q, blk_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [127:0]       txt_q, txt_d;
  logic [127:0]       out_q, out_d;
  logic               abort;

`ifdef TWOFISH_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;

  // Abort on the last allowed RUN cycle if the core still has not finished.
  assign abort = (state_q == S_RUN) && !core_end && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      iv_q    <= '0;
      blk_q   <= '0;
      rem_q   <= '0;
      txt_q   <= '0;
      out_q   <= '0;
`ifdef TWOFISH_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      blk_q   <= blk_d;
      rem_q   <= rem_d;
      txt_q   <= txt_d;
      out_q   <= out_d;
`ifdef TWOFISH_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_blocks_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_end) begin
          state_d = S_OUT;
        end else if (abort) begin
          state_d = S_DONE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_d = key_q;
    iv_d  = iv_q;
    blk_d = blk_q;
    rem_d = rem_q;
    txt_d = txt_q;
    out_d = out_q;
`ifdef TWOFISH_SEQ_TIMEOUT_EN
    tmo_d = (state_q == S_RUN) ? tmo_q + TMO_W'(1) : '0;
    err_d = err_q | abort;
`endif
    if (state_q == S_IDLE && start) begin
      key_d = key_i;
      iv_d  = iv_i;
      blk_d = first_block_i;
      rem_d = num_blocks_i;
`ifdef TWOFISH_SEQ_TIMEOUT_EN
      err_d = 1'b0;
`endif
    end
    if (state_q == S_LOAD && in_valid) begin
      txt_d = in_data;
    end
    if (state_q == S_RUN && core_end) begin
      out_d = core_text_output;
    end
    // Block number wraps naturally at 2^64.
    if (state_q == S_OUT && out_ready) begin
      blk_d = blk_q + 64'd1;
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_comb begin
    in_ready          = !rst && (state_q == S_LOAD);
    out_valid         = !rst && (state_q == S_OUT);
    busy              = !rst && (state_q != S_IDLE);
    done              = !rst && (state_q == S_DONE);
    core_rst          = rst || (state_q != S_RUN);
    out_data          = out_q;
    core_key          = key_q;
    core_iv           = iv_q;
    core_block_number = blk_q;
    core_text_input   = txt_q;
`ifdef TWOFISH_SEQ_TIMEOUT_EN
    error             = err_q;
`endif
  end

endmodule
